// File: rtl/chacha_qr_sched.sv
// ChaCha block-round sequencer: walks the 8 quarter-rounds of each double round
// (4 column, 4 diagonal) and handshakes each one with an external QR datapath.
module chacha_qr_sched #(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       qr_ack,
    output logic       busy,
    output logic       done,
    output logic       qr_req,
    output logic [3:0] qr_a,
    output logic [3:0] qr_b,
    output logic [3:0] qr_c,
    output logic [3:0] qr_d,
    output logic [4:0] round,
    output logic [2:0] step
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] DR_LAST = 4'(DOUBLE_ROUNDS - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [3:0] dr_q, dr_d;
    logic       last_qr;
    logic       active;
    logic [1:0] col;
    logic       diag;

    assign last_qr = (step_q == 3'd7) && (dr_q == DR_LAST);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dr_d    = dr_q;
        if (state_q == S_IDLE) begin
            if (start && !abort) begin
                state_d = S_RUN;
                step_d  = 3'd0;
                dr_d    = 4'd0;
            end
        end else if (abort) begin
            // Abort wins over a same-cycle ack and suppresses the done pulse.
            state_d = S_IDLE;
            step_d  = 3'd0;
            dr_d    = 4'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (qr_ack) begin
                        if (last_qr) begin
                            state_d = S_DONE;
                            step_d  = 3'd0;
                            dr_d    = 4'd0;
                        end else begin
                            state_d = S_GAP;
                            step_d  = step_q + 3'd1;
                            if (step_q == 3'd7) begin
                                dr_d = dr_q + 4'd1;
                            end
                        end
                    end
                end
                S_GAP:   state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            dr_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dr_q    <= dr_d;
        end
    end

    // Moore outputs only: qr_req never sees qr_ack combinationally.
    assign active = (state_q != S_IDLE);
    assign busy   = active;
    assign done   = (state_q == S_DONE);
    assign qr_req = (state_q == S_RUN);

    assign col  = step_q[1:0];
    assign diag = step_q[2];

    // Diagonal steps rotate the b/c/d rows by 1/2/3 columns.
    assign qr_a  = active ? {2'b00, col}                      : 4'd0;
    assign qr_b  = active ? {2'b01, col + {1'b0, diag}}       : 4'd0;
    assign qr_c  = active ? {2'b10, col + {diag, 1'b0}}       : 4'd0;
    assign qr_d  = active ? {2'b11, col + {diag, diag}}       : 4'd0;
    assign round = active ? ({dr_q, 1'b0} + {4'd0, step_q[2]}) : 5'd0;
    assign step  = active ? step_q                            : 3'd0;

endmodule

// File: doc/chacha_qr_sched.md
CHACHA_QR_SCHED -- requirements
Module: chacha_qr_sched

Interface
REQ-001 SHALL have parameter DOUBLE_ROUNDS, default 10, meaning the number of double rounds per block (legal range 1..15; 10 gives ChaCha20).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin one block computation; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancel the current computation and return to IDLE.
REQ-006 SHALL have port qr_ack  input  1  the quarter-round datapath has completed and written back the requested QR.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the final QR is acknowledged.
REQ-009 SHALL have port qr_req  output  1  request that the datapath execute a QR on indices qr_a..qr_d.
REQ-010 SHALL have ports qr_a, qr_b, qr_c, qr_d  output  4 each  state-word indices (0..15) for QR operands a, b, c, d.
REQ-011 SHALL have port round  output  5  current round number, 0..2*DOUBLE_ROUNDS-1.
REQ-012 SHALL have port step  output  3  QR position within the double round, 0..7.

Function
REQ-013 SHALL implement the states IDLE, RUN, GAP and DONE.
REQ-014 IDLE: start=1 and abort=0 -> RUN with step=0 and the double-round counter dr=0; otherwise remain in IDLE.
REQ-015 RUN: qr_req=1 and indices held stable; qr_ack=0 -> stay in RUN; qr_ack=1 and not last QR -> GAP; qr_ack=1 and last QR -> DONE.
REQ-016 GAP: qr_req=0 for exactly one cycle, then RUN with the advanced step; this gives the datapath a write-back settle cycle.
REQ-017 DONE: done=1 and busy=1 for one cycle, then IDLE unconditionally.
REQ-018 Step advance on ack: step increments; when step=7, step wraps to 0 and dr increments.
REQ-019 The last QR SHALL be step=7 with dr=DOUBLE_ROUNDS-1.
REQ-020 Column steps (step=i, i=0..3) SHALL drive a=i, b=4+i, c=8+i, d=12+i.
REQ-021 Diagonal steps (step=4+i) SHALL drive a=i, b=4+((i+1) mod 4), c=8+((i+2) mod 4), d=12+((i+3) mod 4), giving (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
REQ-022 round SHALL equal 2*dr+step[2], combinational from registered dr and step.
REQ-023 qr_a..qr_d, round and step SHALL be driven in all states; in IDLE they SHALL be 0.
REQ-024 qr_ack outside RUN SHALL be ignored.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear step and dr, and override a simultaneous qr_ack; no done pulse is produced.
REQ-027 start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-028 Minimum latency SHALL be: start edge to the first qr_req = 1 cycle; then 2 cycles per QR (ack in the first RUN cycle) minus the final GAP, plus the DONE cycle, for a total of start-to-done = 16*DOUBLE_ROUNDS cycles.
REQ-029 qr_req SHALL depend only on state, so there is no combinational path from qr_ack to qr_req.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, step=0, dr=0, busy=0, done=0, qr_req=0, qr_a..qr_d=0 and round=0.
REQ-031 Reset asserted mid-computation SHALL abandon the computation without a done pulse; after rst_n rises, the block SHALL need a new start.

Verification
REQ-032 Bench SHALL cover: DOUBLE_ROUNDS=10 with qr_ack tied to 1 -> 80 QRs issued, index tuples follow REQ-020/021 each double round, done at cycle 160 after the start edge, round steps 0..19.
REQ-033 Bench SHALL cover: qr_ack delayed 3 cycles per request -> qr_req and indices held stable while waiting, exactly one GAP cycle between requests, step order 0..7 unchanged.
REQ-034 Bench SHALL cover: abort asserted in the same cycle as qr_ack at step=5, dr=2 -> next cycle IDLE, busy=0, no done, outputs 0.
REQ-035 Bench SHALL cover: start pulsed while busy, and qr_ack pulsed in IDLE and GAP -> no change in sequence or state.
REQ-036 Bench SHALL cover: rst_n pulled low asynchronously mid-RUN (between clock edges) -> outputs 0 immediately; after release with start=0 the block stays IDLE.
REQ-037 Bench SHALL cover: DOUBLE_ROUNDS=1 with ack tied high -> 8 QRs, done at cycle 16, round 0 then 1.
